// File: rtl/cache_axi_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_axi_arbiter                                               |
// | Purpose  : Shares one AXI3 master port between the icache refill path,     |
// |            the dcache refill path and the dcache writeback path.           |
// |            Reads: one outstanding AR burst, R beats routed back by ID.     |
// |            Writes: one-line write buffer drained on AW/W/B.                |
// |            A dcache read that targets the line held in the write buffer    |
// |            is stalled until the writeback completes.                       |
// | Ports    : aclk/aresetn (async, active-low)                                |
// |            ic_rd_* / ic_ret_*  icache request and return                   |
// |            dc_rd_* / dc_ret_*  dcache request and return                   |
// |            dc_wr_*             dcache write request                        |
// |            ar*/r*/aw*/w*/b*    AXI3 master channels                        |
// | Options  : ARB_RR_EN  round-robin read arbitration (default: dcache        |
// |                       has fixed priority over icache)                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cache_axi_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  // icache read
  input  logic              ic_rd_req,
  input  logic [2:0]        ic_rd_type,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [31:0]       ic_ret_data,
  // dcache read
  input  logic              dc_rd_req,
  input  logic [2:0]        dc_rd_type,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [31:0]       dc_ret_data,
  // dcache write
  input  logic              dc_wr_req,
  input  logic [2:0]        dc_wr_type,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [3:0]        dc_wr_wstrb,
  input  logic [127:0]      dc_wr_data,
  output logic              dc_wr_rdy,
  // AXI read address
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AXI write address
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [7:0] C_LINE_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [2:0] C_TYPE_LINE = 3'b100;
  localparam logic [2:0] C_SIZE_WORD = 3'b010;
  // Byte-offset bits inside a line; addresses above this identify the line.
  localparam int         C_LINE_OFS  = $clog2(LINE_WORDS * 4);
  // The write data port carries four 32-bit words.
  localparam int         C_BUF_WORDS = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  rd_state_t         r_rd_state, w_rd_state_nxt;
  logic              r_rd_owner;   // 1 = dcache, 0 = icache
  logic [ADDR_W-1:0] r_rd_addr;
  logic [7:0]        r_rd_len;

  wr_state_t         r_wr_state, w_wr_state_nxt;
  logic [ADDR_W-1:0] r_wbuf_addr;
  logic [127:0]      r_wbuf_data;
  logic [3:0]        r_wbuf_strb;
  logic [7:0]        r_wr_len;
  logic [7:0]        r_wr_cnt;     // beats remaining after the current one

  logic              w_wr_busy;
  logic              w_hz_pending;
  logic              w_hz_new;
  logic              w_dc_elig;
  logic              w_pick_dc;
  logic              w_pick_ic;
  logic              w_rd_idle;
  logic              w_grant;
  logic              w_beat_ok;
  logic [7:0]        w_widx;
  logic [31:0]       w_wword;

  // --------------------------------------------------------------------------
  // Read-after-write hazard: a dcache read may not overtake a writeback of
  // the same line. This covers both the line already in the write buffer and
  // a write being accepted in this very cycle.
  // --------------------------------------------------------------------------
  assign w_wr_busy    = (r_wr_state != W_IDLE);
  assign w_hz_pending = w_wr_busy &&
                        (dc_rd_addr[ADDR_W-1:C_LINE_OFS] == r_wbuf_addr[ADDR_W-1:C_LINE_OFS]);
  assign w_hz_new     = !w_wr_busy && dc_wr_req &&
                        (dc_rd_addr[ADDR_W-1:C_LINE_OFS] == dc_wr_addr[ADDR_W-1:C_LINE_OFS]);
  assign w_dc_elig    = dc_rd_req && !w_hz_pending && !w_hz_new;

`ifdef ARB_RR_EN
  logic r_last_grant;  // 1 = dcache was granted last

  // With both eligible, the requester not granted last time wins.
  assign w_pick_dc = w_dc_elig && (!ic_rd_req || !r_last_grant);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_last_grant <= 1'b0;
    end else if (w_grant) begin
      r_last_grant <= w_pick_dc;
    end
  end
`else
  assign w_pick_dc = w_dc_elig;
`endif

  assign w_pick_ic = ic_rd_req && !w_pick_dc;
  // rdy outputs are forced low while reset is held.
  assign w_rd_idle = aresetn && (r_rd_state == R_IDLE);
  assign dc_rd_rdy = w_rd_idle && w_pick_dc;
  assign ic_rd_rdy = w_rd_idle && w_pick_ic;
  assign w_grant   = dc_rd_rdy || ic_rd_rdy;

  // A beat only belongs to us if it carries the owner's ID.
  assign w_beat_ok = rvalid && (rid == {3'b000, r_rd_owner});

  // AR fields come straight from registers so they hold until arready.
  assign arid   = {3'b000, r_rd_owner};
  assign araddr = r_rd_addr;
  assign arlen  = r_rd_len;

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_state <= R_IDLE;
      r_rd_owner <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      if (w_grant) begin
        r_rd_owner <= w_pick_dc;
        r_rd_addr  <= w_pick_dc ? dc_rd_addr : ic_rd_addr;
        if (w_pick_dc) begin
          r_rd_len <= (dc_rd_type == C_TYPE_LINE) ? C_LINE_LEN : 8'd0;
        end else begin
          r_rd_len <= (ic_rd_type == C_TYPE_LINE) ? C_LINE_LEN : 8'd0;
        end
      end
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    arvalid        = 1'b0;
    arsize         = 3'b000;
    rready         = 1'b0;
    ic_ret_valid   = 1'b0;
    ic_ret_last    = 1'b0;
    ic_ret_data    = 32'd0;
    dc_ret_valid   = 1'b0;
    dc_ret_last    = 1'b0;
    dc_ret_data    = 32'd0;
    case (r_rd_state)
      R_IDLE: begin
        if (w_grant) w_rd_state_nxt = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        arsize  = C_SIZE_WORD;
        if (arready) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (w_beat_ok) begin
          if (r_rd_owner) begin
            dc_ret_valid = 1'b1;
            dc_ret_last  = rlast;
            dc_ret_data  = rdata;
          end else begin
            ic_ret_valid = 1'b1;
            ic_ret_last  = rlast;
            ic_ret_data  = rdata;
          end
          if (rlast) w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  assign awaddr = r_wbuf_addr;
  assign awlen  = r_wr_len;

  // The counter runs down, so the word index is len minus what remains.
  assign w_widx = r_wr_len - r_wr_cnt;

  always_comb begin
    w_wword = 32'd0;
    for (int i = 0; i < C_BUF_WORDS; i++) begin
      if (w_widx == 8'(i)) w_wword = r_wbuf_data[i*32 +: 32];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state  <= W_IDLE;
      r_wbuf_addr <= '0;
      r_wbuf_data <= '0;
      r_wbuf_strb <= '0;
      r_wr_len    <= '0;
      r_wr_cnt    <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      if ((r_wr_state == W_IDLE) && dc_wr_req) begin
        r_wbuf_addr <= dc_wr_addr;
        r_wbuf_data <= dc_wr_data;
        if (dc_wr_type == C_TYPE_LINE) begin
          r_wbuf_strb <= 4'hF;
          r_wr_len    <= C_LINE_LEN;
          r_wr_cnt    <= C_LINE_LEN;
        end else begin
          r_wbuf_strb <= dc_wr_wstrb;
          r_wr_len    <= 8'd0;
          r_wr_cnt    <= 8'd0;
        end
      end else if ((r_wr_state == W_DATA) && wready && (r_wr_cnt != 8'd0)) begin
        r_wr_cnt <= r_wr_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    dc_wr_rdy      = 1'b0;
    awvalid        = 1'b0;
    awsize         = 3'b000;
    wvalid         = 1'b0;
    wdata          = 32'd0;
    wstrb          = 4'h0;
    wlast          = 1'b0;
    bready         = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        dc_wr_rdy = aresetn;
        if (dc_wr_req) w_wr_state_nxt = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        awsize  = C_SIZE_WORD;
        if (awready) w_wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wdata  = w_wword;
        wstrb  = r_wbuf_strb;
        wlast  = (r_wr_cnt == 8'd0);
        if (wready && (r_wr_cnt == 8'd0)) w_wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

endmodule
`default_nettype wire
